modinv_32: RTL and testbench



---
 rtl/modinv_32.sv | 132 +++++++++++++
 tb/tb_modinv_32.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/modinv_32.sv
// Modular inverse d = e^-1 mod m via extended Euclid; each quotient is formed
// bit-serially by a restoring shift-subtract loop that also updates the cofactor.
module modinv_32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] ina,
    input  logic [31:0] inb,
    output logic [31:0] result,
    output logic        err,
    output logic        ready_n,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DIV  = 3'd1,
        SWAP = 3'd2,
        FIN  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [31:0]        r0, r1, m_reg;
    logic signed [33:0] t0, t1;
    logic [4:0]         i;
    logic               degen;

    logic               degen_in;
    logic [63:0]        r_term;
    logic               fits;
    logic [31:0]        r_diff;
    logic signed [33:0] t_term;
    logic signed [33:0] t_diff;

    assign state_dbg = state;
    assign degen_in  = (ina == 32'd0) || (inb < 32'd2);

    // One restoring-divider step: subtract r1<<i when it fits, and mirror the
    // same subtraction on the cofactor. Cofactor arithmetic is exact modulo 2^34.
    assign r_term = {32'd0, r1} << i;
    assign fits   = (r_term <= {32'd0, r0});
    assign r_diff = r0 - r_term[31:0];
    assign t_term = t1 <<< i;
    assign t_diff = t0 - t_term;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = degen_in ? FIN : DIV;
                end
            end
            DIV: begin
                if (i == 5'd0) begin
                    state_nxt = SWAP;
                end
            end
            // r0 holds the fresh remainder that becomes r1 after the swap.
            SWAP:    state_nxt = (r0 == 32'd0) ? FIN : DIV;
            FIN:     state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0      <= 32'd0;
            r1      <= 32'd0;
            t0      <= 34'sd0;
            t1      <= 34'sd0;
            m_reg   <= 32'd0;
            i       <= 5'd0;
            degen   <= 1'b0;
            result  <= 32'd0;
            err     <= 1'b0;
            ready_n <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        r0      <= inb;
                        r1      <= ina;
                        t0      <= 34'sd0;
                        t1      <= 34'sd1;
                        m_reg   <= inb;
                        i       <= 5'd31;
                        degen   <= degen_in;
                        ready_n <= 1'b1;
                    end
                end
                DIV: begin
                    if (fits) begin
                        r0 <= r_diff;
                        t0 <= t_diff;
                    end
                    i <= i - 5'd1;
                end
                SWAP: begin
                    r0 <= r1;
                    r1 <= r0;
                    t0 <= t1;
                    t1 <= t0;
                    i  <= 5'd31;
                end
                FIN: begin
                    if (degen || (r0 != 32'd1)) begin
                        err    <= 1'b1;
                        result <= 32'd0;
                    end else begin
                        err    <= 1'b0;
                        // |t0| < m, so the low 32 bits of t0 + m are exact.
                        result <= t0[33] ? (t0[31:0] + m_reg) : t0[31:0];
                    end
                    ready_n <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_modinv_32.sv
// Bench for modinv_32: constant vector table, hand-written busy/reset/restart
// sequences and a random coprime sweep against an integer extended-Euclid model.
module tb_modinv_32;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] ina;
    logic [31:0] inb;
    logic [31:0] result;
    logic        err;
    logic        ready_n;
    logic [2:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    logic [32:0] exp_q[$];   // {err, result}
    int          lat_q[$];

    typedef struct {
        string       name;
        logic [31:0] e;
        logic [31:0] m;
        logic [31:0] exp_res;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[11];

    modinv_32 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ina       (ina),
        .inb       (inb),
        .result    (result),
        .err       (err),
        .ready_n   (ready_n),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Integer extended Euclid with '/' and '%'; n counts quotients.
    task automatic ref_inv(input logic [31:0] e, input logic [31:0] m,
                           output logic [31:0] inv, output logic er, output int n);
        longint r0, r1, t0, t1, q, tmp;
        n = 0;
        if (e == 0 || m < 2) begin
            inv = 0;
            er  = 1'b1;
            return;
        end
        r0 = longint'(m);
        r1 = longint'(e);
        t0 = 0;
        t1 = 1;
        while (r1 != 0) begin
            q   = r0 / r1;
            tmp = r0 % r1;
            r0  = r1;
            r1  = tmp;
            tmp = t0 - q * t1;
            t0  = t1;
            t1  = tmp;
            n++;
        end
        if (r0 != 1) begin
            er  = 1'b1;
            inv = 0;
        end else begin
            er  = 1'b0;
            if (t0 < 0) t0 = t0 + longint'(m);
            inv = t0[31:0];
        end
    endtask

    // ---------------- driver ----------------
    // Latency counts the sampling edge as edge 1.
    task automatic launch(input logic [31:0] e, input logic [31:0] m,
                          input logic [31:0] exp_res, input logic exp_err, input int exp_lat);
        @(negedge clk);
        ina   = e;
        inb   = m;
        start = 1'b1;
        exp_q.push_back({exp_err, exp_res});
        lat_q.push_back(exp_lat);
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic finish_op(input string name);
        logic [32:0] exp;
        int          exp_lat;
        int          lat;
        while (ready_n === 1'b1 && (cyc - start_cyc) < 2000) @(negedge clk);
        lat = cyc - start_cyc + 1;
        if (ready_n !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: ready_n=%0b after %0d edges, required 0", name, ready_n, lat);
        end
        exp     = exp_q.pop_front();
        exp_lat = lat_q.pop_front();
        check({name, "_result"}, 64'(result), 64'(exp[31:0]));
        check({name, "_err"}, 64'(err), 64'(exp[32]));
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    endtask

    // ---------------- test ----------------
    initial begin
        logic [31:0] e, m, inv;
        logic        er;
        int          n;
        logic [63:0] prod;

        vecs[0]  = '{"rsa",       32'd17,         32'd3120,       32'd2753, 1'b0, 134};
        vecs[1]  = '{"small",     32'd3,          32'd20,         32'd7,    1'b0, 101};
        vecs[2]  = '{"e_gt_m",    32'd23,         32'd20,         32'd7,    1'b0, 167};
        vecs[3]  = '{"noncop",    32'd6,          32'd20,         32'd0,    1'b1, 68};
        vecs[4]  = '{"e_zero",    32'd0,          32'd20,         32'd0,    1'b1, 2};
        vecs[5]  = '{"m_one",     32'd5,          32'd1,          32'd0,    1'b1, 2};
        vecs[6]  = '{"m_two",     32'd1,          32'd2,          32'd1,    1'b0, 35};
        vecs[7]  = '{"m_two_b",   32'd3,          32'd2,          32'd1,    1'b0, 101};
        vecs[8]  = '{"e_eq_m",    32'd20,         32'd20,         32'd0,    1'b1, 35};
        vecs[9]  = '{"f4_fact",   32'd65537,      32'hFFFF_FFFF,  32'd0,    1'b1, 35};
        vecs[10] = '{"max_ops",   32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,    1'b0, 101};

        rst   = 1'b1;
        start = 1'b0;
        ina   = 32'd0;
        inb   = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_ready_n", 64'(ready_n), 64'd1);
        check("reset_result", 64'(result), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        check("reset_state", 64'(state_dbg), 64'd0);
        rst = 1'b0;

        for (int k = 0; k < 11; k++) begin
            launch(vecs[k].e, vecs[k].m, vecs[k].exp_res, vecs[k].exp_err, vecs[k].exp_lat);
            check({vecs[k].name, "_busy_ready_n"}, 64'(ready_n), 64'd1);
            finish_op(vecs[k].name);
        end

        // Restart from DONE: ready_n rises on the sampling edge, old result holds.
        launch(32'd3, 32'd20, 32'd7, 1'b0, 101);
        finish_op("pre_restart");
        launch(32'd23, 32'd20, 32'd7, 1'b0, 167);
        check("restart_ready_n", 64'(ready_n), 64'd1);
        launch_hold_check();
        finish_op("restart");

        // start pulses while busy must not disturb the run in progress.
        launch(32'd17, 32'd3120, 32'd2753, 1'b0, 134);
        repeat (8) @(negedge clk);
        ina   = 32'd3;
        inb   = 32'd20;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_op("busy_start");

        // Asynchronous reset in the middle of a DIV pass.
        launch(32'd17, 32'd3120, 32'd2753, 1'b0, 134);
        while ((cyc - start_cyc) < 39) @(negedge clk);
        check("midrun_state_div", 64'(state_dbg), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("midrun_rst_ready_n", 64'(ready_n), 64'd1);
        check("midrun_rst_result", 64'(result), 64'd0);
        check("midrun_rst_err", 64'(err), 64'd0);
        check("midrun_rst_state", 64'(state_dbg), 64'd0);
        exp_q.delete();
        lat_q.delete();
        @(negedge clk);
        rst = 1'b0;
        launch(32'd17, 32'd3120, 32'd2753, 1'b0, 134);
        finish_op("after_reset");

        // Random coprime sweep, alternating full-range and small moduli.
        for (int k = 0; k < 20; k++) begin
            er = 1'b1;
            for (int tries = 0; tries < 100 && er; tries++) begin
                m = (k % 2 == 0) ? $urandom : 32'($urandom_range(1000, 2));
                if (m < 2) m = 32'd2;
                e = $urandom;
                ref_inv(e, m, inv, er, n);
            end
            launch(e, m, inv, 1'b0, 33 * n + 2);
            finish_op("rand");
            prod = {32'd0, e} * {32'd0, result};
            check("rand_inverse", prod % {32'd0, m}, 64'd1);
            check("rand_in_range", 64'(result < m), 64'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // While the restarted run is busy, the previous result and err must hold.
    task automatic launch_hold_check();
        repeat (20) @(negedge clk);
        check("restart_hold_result", 64'(result), 64'd7);
        check("restart_hold_err", 64'(err), 64'd0);
        check("restart_hold_ready_n", 64'(ready_n), 64'd1);
    endtask

endmodule
